// File: rtl/dff_pipe.sv
// Stallable register pipeline: DEPTH stages of WIDTH bits with valid/ready
// handshaking, bubble collapsing, synchronous flush and complemented output.
module dff_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [WIDTH-1:0]           out_ndata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned N  = unsigned'(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    if (DEPTH < 1) begin : g_depth_check
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic [N-1:0]     v;
    logic [N-1:0]     ready;
    logic [WIDTH-1:0] d [N];
    logic             accept;

    // Readiness ripples from the output side, so any bubble frees every stage upstream of it.
    always_comb begin
        ready        = '0;
        ready[N-1]   = !v[N-1] || out_ready;
        for (int unsigned k = 1; k < N; k++) begin
            ready[N-1-k] = !v[N-1-k] || ready[N-k];
        end
    end

    assign in_ready = rst_n && ready[0] && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (ready[0]) begin
                v[0] <= accept;
            end
            if (accept) begin
                d[0] <= in_data;
            end
            for (int unsigned i = 1; i < N; i++) begin
                if (ready[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + CW'(v[i]);
        end
    end

    assign out_valid = v[N-1];
    assign out_data  = d[N-1];
    assign out_ndata = ~d[N-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a word/position queue model predicts the DEPTH=4 pipe;
// a second DEPTH=1 instance covers the single-flop handshake case.
module tb_dff_pipe;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid;
    logic [7:0] out_data, out_ndata;
    logic [2:0] count;

    logic       s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [7:0] s_in_data = 8'h00;
    logic       s_in_ready, s_out_valid, s_count;
    logic [7:0] s_out_data, s_out_ndata;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ndata(out_ndata), .count(count)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ndata(s_out_ndata), .count(s_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: each word in flight with the stage it occupies, oldest first.
    logic [7:0] mq_d[$];
    int         mq_p[$];
    bit         madv[8];
    bit         exp_ready, exp_valid, accepted;
    logic [7:0] exp_data;
    int         exp_count;

    task automatic drive(input bit v, input logic [7:0] dd, input bit r, input bit f);
        @(negedge clk);
        in_valid = v; in_data = dd; out_ready = r; flush = f;
        #1;
        for (int k = 0; k < mq_d.size(); k++) begin
            if (mq_p[k] == D-1) madv[k] = r;
            else if (k == 0) madv[k] = 1'b1;
            else madv[k] = (mq_p[k-1] != mq_p[k] + 1) || madv[k-1];
        end
        exp_ready = !f && (mq_d.size() == 0 || mq_p[mq_p.size()-1] != 0 || madv[mq_d.size()-1]);
        exp_valid = mq_d.size() > 0 && mq_p[0] == D-1;
        exp_data  = exp_valid ? mq_d[0] : 8'h00;
        exp_count = mq_d.size();
        accepted  = v && exp_ready;
    endtask

    task automatic step();
        logic [7:0] nd[$];
        int         np[$];
        @(posedge clk);
        if (!flush) begin
            for (int k = 0; k < mq_d.size(); k++) begin
                if (!madv[k]) begin
                    nd.push_back(mq_d[k]); np.push_back(mq_p[k]);
                end else if (mq_p[k] != D-1) begin
                    nd.push_back(mq_d[k]); np.push_back(mq_p[k] + 1);
                end
            end
            if (accepted) begin
                nd.push_back(in_data); np.push_back(0);
            end
        end
        mq_d = nd; mq_p = np;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({out_valid, count, out_data, out_ndata, in_ready} !== {1'b0, 3'd0, 8'hA5, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b count=%0d data=%h ndata=%h ready=%b, want 0 0 a5 5a 0",
                     out_valid, count, out_data, out_ndata, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        int acc_c = -1;
        int emg_c = -1;
        for (int i = 0; i < 14; i++) begin
            drive(i < 8, 8'(i + 1), 1'b1, 1'b0);
            checks++;
            if ({in_ready, out_valid, count} !== {exp_ready, exp_valid, 3'(exp_count)} ||
                (exp_valid && out_data !== exp_data)) begin
                errors++;
                $display("FAIL latency_cycle%0d: got ready=%b valid=%b count=%0d data=%h, want %b %b %0d %h",
                         i, in_ready, out_valid, count, out_data, exp_ready, exp_valid, exp_count, exp_data);
            end
            if (i == 0 && in_valid && in_ready) acc_c = cyc;
            if (out_valid && out_data == 8'h01 && emg_c < 0) emg_c = cyc;
            step();
        end
        checks++;
        if (acc_c < 0 || emg_c - acc_c != D) begin
            errors++;
            $display("FAIL latency_first_word: got %0d cycles want %0d", emg_c - acc_c, D);
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        logic [7:0] got[$];
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
            checks++;
            if ({in_ready, out_valid, count} !== {exp_ready, exp_valid, 3'(exp_count)}) begin
                errors++;
                $display("FAIL backpressure_fill%0d: got ready=%b valid=%b count=%0d, want %b %b %0d",
                         i, in_ready, out_valid, count, exp_ready, exp_valid, exp_count);
            end
            if (in_ready) n_acc++;
            step();
        end
        checks++;
        if (n_acc != 4) begin
            errors++;
            $display("FAIL backpressure_accepts: got %0d want 4", n_acc);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            if (out_valid) got.push_back(out_data);
            step();
        end
        checks++;
        if (got.size() != 4 || got[0] !== 8'h10 || got[1] !== 8'h11 || got[2] !== 8'h12 || got[3] !== 8'h13) begin
            errors++;
            $display("FAIL backpressure_drain: got %0d words first=%h, want 4 words 10..13",
                     got.size(), got.size() > 0 ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_bubble();
        drive(1'b1, 8'h20, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();
        drive(1'b1, 8'h21, 1'b0, 1'b0); step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if ({in_ready, out_valid, count} !== {exp_ready, exp_valid, 3'(exp_count)}) begin
                errors++;
                $display("FAIL bubble_cycle%0d: got ready=%b valid=%b count=%0d, want %b %b %0d",
                         i, in_ready, out_valid, count, exp_ready, exp_valid, exp_count);
            end
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({count, in_ready, out_valid, out_data} !== {3'd2, 1'b1, 1'b1, 8'h20}) begin
            errors++;
            $display("FAIL bubble_collapsed: got count=%0d ready=%b valid=%b data=%h, want 2 1 1 20",
                     count, in_ready, out_valid, out_data);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (exp_valid && out_data !== exp_data) begin
                errors++;
                $display("FAIL bubble_drain%0d: got %h want %h", i, out_data, exp_data);
            end
            step();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0); step();
        end
        drive(1'b1, 8'h40, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out_data, in_ready, count} !== {1'b1, 8'h30, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL flush_cycle: got valid=%b data=%h ready=%b count=%0d, want 1 30 0 4",
                     out_valid, out_data, in_ready, count);
        end
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_after: got count=%0d valid=%b ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] prev = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0); step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'($urandom), 1'b1, 1'b0);
            checks++;
            if ({in_ready, count, out_valid} !== {1'b1, 3'd4, 1'b1} || out_data !== exp_data) begin
                errors++;
                $display("FAIL b2b_d4_cycle%0d: got ready=%b count=%0d valid=%b data=%h, want 1 4 1 %h",
                         i, in_ready, count, out_valid, out_data, exp_data);
            end
            step();
        end
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            s_in_data = 8'($urandom);
            #1;
            checks++;
            if (s_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_d1_ready%0d: got %b want 1", i, s_in_ready);
            end
            if (i > 0) begin
                checks++;
                if ({s_out_valid, s_count, s_out_data, s_out_ndata} !== {1'b1, 1'b1, prev, ~prev}) begin
                    errors++;
                    $display("FAIL b2b_d1_data%0d: got valid=%b count=%0d data=%h ndata=%h, want 1 1 %h %h",
                             i, s_out_valid, s_count, s_out_data, s_out_ndata, prev, ~prev);
                end
            end
            prev = s_in_data;
            step();
        end
        s_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0); step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
            checks++;
            if ({in_ready, out_valid, count} !== {exp_ready, exp_valid, 3'(exp_count)} ||
                (exp_valid && (out_data !== exp_data || out_ndata !== ~exp_data))) begin
                errors++;
                $display("FAIL random_cycle%0d: got ready=%b valid=%b count=%0d data=%h, want %b %b %0d %h",
                         i, in_ready, out_valid, count, out_data, exp_ready, exp_valid, exp_count, exp_data);
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0); step();
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq_d.delete(); mq_p.delete();
        checks++;
        if ({out_valid, count, out_data, out_ndata, in_ready} !== {1'b0, 3'd0, 8'hA5, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL reset_midstream: got valid=%b count=%0d data=%h ndata=%h ready=%b, want 0 0 a5 5a 0",
                     out_valid, count, out_data, out_ndata, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({in_ready, count} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_midstream_release: got ready=%b count=%0d, want 1 0", in_ready, count);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_bubble();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised register pipeline: a chain of DEPTH data-flop stages of WIDTH bits each, with valid/ready flow control, bubble collapsing and a synchronous flush. It generalises the single D flip-flop to a multi-bit, multi-stage buffer. It sits between FIFO producer and consumer logic wherever a fixed-latency, stallable retiming path is needed. Like the single flop, it drives both true and complemented outputs.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1); elaboration error if <1
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous and active-low
- flush  in  1  synchronous flush: invalidates all stages at next edge
- in_valid  in  1  producer has a word
- in_ready  out  1  pipeline accepts a word this cycle
- in_data  in  WIDTH  producer word
- out_valid  out  1  last stage holds a valid word
- out_ready  in  1  consumer takes the word this cycle
- out_data  out  WIDTH  last-stage data
- out_ndata  out  WIDTH  bitwise complement of out_data
- count  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): v[i] and d[i].
- Stage advance: adv[DEPTH-1] = out_ready. adv[i] = ready[i+1] for i < DEPTH-1.
- Stage readiness: ready[i] = !v[i] || adv[i]. This is a combinational chain, so a bubble anywhere lets upstream stages move.
- in_ready = ready[0] && !flush.
- Input accept occurs when in_valid && in_ready: at the edge, d[0] <= in_data and v[0] <= 1.
- Stage move: when ready[i] is true and i > 0, d[i] <= d[i-1] and v[i] <= v[i-1] at the edge. d[i] loads only when v[i-1] = 1; otherwise it holds its old value.
- If ready[0] is true and there is no accept, v[0] <= 0.
- A stage with ready[i] = 0 holds both v[i] and d[i].
- Output transfer occurs when out_valid && out_ready.
  - out_valid = v[DEPTH-1].
  - out_data = d[DEPTH-1], shown even when out_valid = 0.
- count = popcount(v), derived from the registered v bits.
- Flush: at the edge with flush=1, every v[i] <= 0.
  - d[i] is not cleared.
  - An output transfer in that same cycle still completes for the consumer.
  - No input is accepted in that cycle.
  - Flush takes priority over all moves.
- Reset (rst_n=0, asynchronous): v = 0, every d[i] = RESET_VAL, count = 0, out_valid = 0, out_data = RESET_VAL, out_ndata = ~RESET_VAL.
  - While reset is held, in_ready = 0.
  - After release, in_ready = 1 in the first cycle (unless flush is asserted).
  - Reset mid-stream discards all words immediately, with no glitch-free guarantee on outputs during assertion.
- Words are never duplicated, dropped (except by flush/reset) or reordered.

## Timing
- Latency: a word accepted at edge E, with no stalls, reaches out_valid=1 after edge E+DEPTH-1. Equivalently, it appears DEPTH cycles after the accepting cycle.
- Throughput: one word per cycle sustained while out_ready=1.
- Capacity: DEPTH words. With out_ready=0 and the pipe full, in_ready=0.
- Full pipe with out_ready=1: in_ready=1 in the same cycle (simultaneous push/pop), and count stays DEPTH.
- A bubble collapses by one stage per stalled cycle. A stalled pipe with k valid words and out_ready=0 accepts DEPTH-k further words, one per cycle.
- in_ready depends combinationally on out_ready and flush. All other outputs are registered-only.
- DEPTH=1: in_ready = !v[0] || out_ready, i.e. a single flop with handshake.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle with 3 words in flight (WIDTH=8, RESET_VAL=8'hA5) -> immediately out_valid=0, count=0, out_data=8'hA5, out_ndata=8'h5A. After release, in_ready=1.
- Latency/throughput (DEPTH=4, out_ready=1): push 8'h01..8'h08 on consecutive cycles -> 8'h01 emerges 4 cycles after its accept, then one word per cycle in order, with count steady at 4 during the stream.
- Back-pressure: out_ready=0, push 8'h10..8'h15 continuously -> exactly 4 accepted (8'h10..8'h13) and in_ready=0 after the 4th. With out_ready=1, 8'h10..8'h13 drain in order.
- Bubble collapse: load 8'h20, idle 2 cycles, load 8'h21, then out_ready=0 -> within 4 cycles both words sit in stages 3 and 2 (count=2) and in_ready=1.
- Flush: pipe full with 8'h30..8'h33, out_ready=1, flush=1 for one cycle with in_valid=1 and in_data=8'h40 -> 8'h30 is delivered that cycle, 8'h40 is not accepted, and next cycle count=0 and out_valid=0.
- Simultaneous push/pop at full (DEPTH=1 and DEPTH=4): out_ready=1 and in_valid=1 every cycle -> in_ready never drops, count stays constant, and there is no word loss.
